// File: rtl/button_pkg.sv
// Shared constants for the pushbutton/slide-switch input conditioner.
package button_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;  // 20 ms at 50 MHz
  localparam int unsigned REPEAT_DELAY_DEF    = 25000000; // 500 ms at 50 MHz
  localparam int unsigned REPEAT_PERIOD_DEF   = 5000000;  // 100 ms at 50 MHz

  localparam int unsigned CNT_W = 20;  // debounce counter width
  localparam int unsigned RPT_W = 26;  // auto-repeat counter width

  localparam int unsigned N_KEY = 2;
  localparam int unsigned N_SW  = 2;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchroniser, debounce counter, stable level
// register and single-cycle rising-edge pulse register.
// Optional key auto-repeat is compiled in with BTN_AUTOREPEAT_EN.
module debounce_channel
  import button_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = button_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = button_pkg::CNT_W,
  parameter int unsigned REPEAT_DELAY    = button_pkg::REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = button_pkg::REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  // Reject parameter sets the counters cannot represent.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      REPEAT_DELAY > (2 ** RPT_W) || REPEAT_PERIOD > (2 ** RPT_W)) begin : g_param_check
    $error("debounce_channel: parameter out of range");
  end

  logic             in_act;
  logic             s1, s2;
  logic             stable, stable_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise;
  logic             fire;

  assign in_act = ACTIVE_LOW ? ~raw : raw;
  assign level  = stable;

  // Debounce next-state: count while the synchronised input differs from the
  // accepted level, accept on the terminal count, restart on any agreement.
  always_comb begin
    cnt_nxt    = '0;
    stable_nxt = stable;
    if (s2 != stable) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_nxt = s2;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
    rise = stable_nxt & ~stable;
  end

`ifdef BTN_AUTOREPEAT_EN
  logic [RPT_W-1:0] rcnt;
  logic             rpt_first;
  logic             rpt_fire;

  // Repeat fires when the held key reaches the initial delay, then each period.
  always_comb begin
    rpt_fire = 1'b0;
    if (REPEAT_EN && stable_nxt && !rise) begin
      if (rpt_first) rpt_fire = (rcnt == RPT_W'(REPEAT_DELAY - 1));
      else           rpt_fire = (rcnt == RPT_W'(REPEAT_PERIOD - 1));
    end
  end

  // Repeat counter measures cycles since the last emitted pulse while held.
  always_ff @(posedge clk) begin
    if (rst || !REPEAT_EN || !stable_nxt || rise) begin
      rcnt      <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rcnt      <= '0;
      rpt_first <= 1'b0;
    end else begin
      rcnt <= rcnt + RPT_W'(1);
    end
  end

  assign fire = rise | rpt_fire;
`else
  assign fire = rise;
`endif

  // Synchroniser, debounce state and pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      s1     <= in_act;
      s2     <= s1;
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
      pulse  <= fire;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions 2 active-low KEY and 2 active-high SW inputs into debounced
// levels and single-cycle activation pulses.
// Optional: BTN_AUTOREPEAT_EN adds auto-repeat pulses on held KEY channels.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = button_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = button_pkg::CNT_W,
  parameter int unsigned REPEAT_DELAY    = button_pkg::REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = button_pkg::REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_KEY-1:0] KEY,
  input  logic [N_SW-1:0]  SW,
  output logic [N_KEY-1:0] key_level,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_KEY-1:0] key_pulse,
  output logic [N_SW-1:0]  sw_pulse
);

  // Pushbutton channels: inverted at input, auto-repeat capable.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_channel #(
      .ACTIVE_LOW      (1'b1),
      .REPEAT_EN       (1'b1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (KEY[i]),
      .level (key_level[i]),
      .pulse (key_pulse[i])
    );
  end

  // Slide switch channels: active-high, never auto-repeat.
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_channel #(
      .ACTIVE_LOW      (1'b0),
      .REPEAT_EN       (1'b0),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (SW[i]),
      .level (sw_level[i]),
      .pulse (sw_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] KEY;
  logic [1:0] SW;
  logic [1:0] key_level, sw_level, key_pulse, sw_pulse;

  int n_checks = 0;
  int n_errors = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .KEY       (KEY),
    .SW        (SW),
    .key_level (key_level),
    .sw_level  (sw_level),
    .key_pulse (key_pulse),
    .sw_pulse  (sw_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    KEY = 2'b11;
    SW  = 2'b00;
    tick();
    tick();
    check("rst_key_level", key_level, 2'b00);
    check("rst_sw_level",  sw_level,  2'b00);
    check("rst_key_pulse", key_pulse, 2'b00);
    check("rst_sw_pulse",  sw_pulse,  2'b00);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_key_pulse", key_pulse, 2'b00);
    end

    // Clean press of KEY[0]: pulse and level at the 6th edge after driving.
    KEY = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("press_pulse", key_pulse, (i == 6) ? 2'b01 : 2'b00);
      check("press_level", key_level, (i >= 6) ? 2'b01 : 2'b00);
    end
    KEY = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("release_pulse", key_pulse, 2'b00);
      check("release_level", key_level, (i >= 6) ? 2'b00 : 2'b01);
    end

    // Bounce on SW[1]: 2-cycle runs never reach the terminal count.
    for (int b = 0; b < 4; b++) begin
      SW = (b % 2 == 0) ? 2'b10 : 2'b00;
      for (int i = 0; i < 2; i++) begin
        tick();
        check("bounce_quiet", sw_pulse, 2'b00);
        check("bounce_level", sw_level, 2'b00);
      end
    end
    SW = 2'b10;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("bounce_pulse", sw_pulse, (i == 6) ? 2'b10 : 2'b00);
      check("bounce_level_final", sw_level, (i >= 6) ? 2'b10 : 2'b00);
    end
    SW = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("sw_off_pulse", sw_pulse, 2'b00);
    end
    check("sw_off_level", sw_level, 2'b00);

    // Both keys pressed together.
    KEY = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("simul_pulse", key_pulse, (i == 6) ? 2'b11 : 2'b00);
    end
    check("simul_level", key_level, 2'b11);
    KEY = 2'b11;
    for (int i = 1; i <= 10; i++) tick();
    check("simul_release", key_level, 2'b00);

    // 3-cycle glitch on KEY[1] is rejected.
    KEY = 2'b01;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) KEY = 2'b11;
      tick();
      check("glitch3_pulse", key_pulse, 2'b00);
      check("glitch3_level", key_level, 2'b00);
    end

    // 4-cycle low on KEY[1] is the shortest accepted activation.
    KEY = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) KEY = 2'b11;
      tick();
      check("glitch4_pulse", key_pulse, (i == 6) ? 2'b10 : 2'b00);
      check("glitch4_level", key_level, (i >= 6 && i < 10) ? 2'b10 : 2'b00);
    end

    // Reset mid-count (cnt=2) with KEY[1] held across it.
    KEY = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("prerst_pulse", key_pulse, 2'b00);
    end
    rst = 1'b1;
    tick();
    check("midrst_pulse", key_pulse, 2'b00);
    check("midrst_level", key_level, 2'b00);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("postrst_pulse", key_pulse, (i == 6) ? 2'b10 : 2'b00);
    end
    KEY = 2'b11;
    for (int i = 1; i <= 10; i++) tick();
    check("postrst_release", key_level, 2'b00);

`ifdef BTN_AUTOREPEAT_EN
    // KEY[0] held 30 cycles: press pulse, then +10, then every 3.
    KEY = 2'b10;
    for (int i = 1; i <= 45; i++) begin
      logic [1:0] exp_p;
      tick();
      if (i == 30) KEY = 2'b11;
      exp_p = (i == 6 || (i >= 16 && i <= 34 && ((i - 16) % 3 == 0))) ? 2'b01 : 2'b00;
      check("repeat_pulse", key_pulse, exp_p);
    end
    check("repeat_release", key_level, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Clocked input-conditioning stage between the raw board pushbuttons/slide switches and the up/down counter logic.
- Synchronises, debounces and edge-detects 2 active-low KEY inputs and 2 active-high SW inputs.
- Emits one single-cycle pulse per debounced activation, so the downstream counter steps exactly once per press/flip instead of once per clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz); legal range 1..2^CNT_W-1
- CNT_W, 20, width of each debounce counter
- REPEAT_DELAY, 25000000, cycles a key must be held before auto-repeat starts (used only with BTN_AUTOREPEAT_EN)
- REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses (used only with BTN_AUTOREPEAT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- KEY  in  2  raw pushbuttons, active-low, asynchronous to clk
- SW  in  2  raw slide switches, active-high, asynchronous to clk
- key_level  out  2  debounced key state, 1 = pressed
- sw_level  out  2  debounced switch state, 1 = on
- key_pulse  out  2  1-cycle pulse on debounced press (0->1 of key_level)
- sw_pulse  out  2  1-cycle pulse on debounced switch-on (0->1 of sw_level)

Behaviour:
- Four independent channels. KEY is inverted at input, so every channel works internally as active-high.
- Per channel, the pipeline is: 2-FF synchroniser (s1, s2) -> debounce counter cnt -> stable register -> pulse register.
- Reset (synchronous to clk, overrides everything):
  - s1 and s2 cleared to the inactive level.
  - cnt = 0.
  - key_level, sw_level, key_pulse and sw_pulse all = 0.
- Debounce rule, evaluated each clock edge:
  - If s2 == stable: cnt <= 0.
  - If s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - A single cycle of s2 == stable during counting restarts the count from 0, so glitches shorter than DEBOUNCE_CYCLES are rejected entirely.
- Pulse:
  - pulse <= 1 on the same edge that stable goes 0->1; 0 on every other edge.
  - Pulse width is exactly 1 cycle.
  - No pulse is generated on release/switch-off.
- Latency: with edge e0 the first edge at which s1 captures the new raw level, stable and pulse update at edge e0+DEBOUNCE_CYCLES+1. The output is visible during the following cycle.
- Held inputs:
  - key_level and sw_level remain 1 for as long as the input stays active.
  - No further pulses are generated unless BTN_AUTOREPEAT_EN is defined.
- Input active during or at release of reset: treated as a fresh activation. Exactly one pulse is emitted DEBOUNCE_CYCLES+2 cycles after rst deasserts.
- Reset asserted mid-count or mid-pulse: all state is discarded the next cycle, and no partial pulse is emitted.
- Simultaneous events: channels are fully independent. Both key_pulse bits, or any combination of key and sw pulses, may assert in the same cycle. Priority is resolved downstream.
- cnt never exceeds DEBOUNCE_CYCLES-1. There is no wrap-around path.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN
- Defined, KEY channels only:
  - While key_level is held at 1, a repeat counter runs.
  - First extra pulse at REPEAT_DELAY cycles after the initial press pulse.
  - Then one pulse every REPEAT_PERIOD cycles.
  - Release or rst clears the repeat counter.
  - SW channels are unaffected.
- Undefined: the repeat counters and their logic are absent; exactly one pulse per press.

Decomposition:
- Shared package button_pkg holds:
  - default constants DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF
  - CNT_W
  - the channel count constants N_KEY=2, N_SW=2
- One natural sub-module: debounce_channel.
  - Contains one synchroniser, debounce counter, stable register and pulse register.
  - Has an ACTIVE_LOW parameter.
  - Contains the repeat logic under the macro, enabled per instance.
  - The top instantiates it 4 times.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: KEY[0] 1->0 and held 20 cycles -> key_pulse[0]=1 for exactly 1 cycle, at e0+5; key_level[0]=1 until release; no pulse on release.
- Bounce rejection: SW[1] toggled 1,0,1,0,1 with 2-cycle spacing, then held 1 -> exactly one sw_pulse[1], 5 cycles after the final stable edge.
- Simultaneous: KEY[0] and KEY[1] pressed on the same cycle -> both key_pulse bits high on the same cycle, one cycle wide.
- Reset: press held across a rst pulse mid-count (cnt=2) -> no pulse during or immediately after rst; one pulse 6 cycles after rst deasserts.
- Short glitch: KEY[1] low for 3 cycles, then high -> no key_pulse[1]; key_level[1] stays 0.
- Auto-repeat (macro defined): KEY[0] held 30 cycles -> pulses at press+0, +10, +13, +16, +19, +22, +25, +28; none after release.
